// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and constants for the pipeline stage register.
// Imported by pipe_stage_reg and pipe_sat_counter.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    localparam int unsigned OCC_MAX = 2;
    localparam int unsigned OCC_W   = $clog2(OCC_MAX + 1);
    localparam int unsigned PERF_W  = 32;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready stream carrying a held data word and a bubble-masked control word.
// The producer side uses the master modport, the consumer side the slave modport.
interface pipe_stage_reg_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 24
);

    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (output valid, output data, output ctrl, input  ready);
    modport slave  (input  valid, input  data, input  ctrl, output ready);

endinterface

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
// Used by pipe_stage_reg for its stall/bubble statistics (PIPE_STAGE_PERF_EN).
module pipe_sat_counter
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = PERF_W
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register: valid/ready handshake, flush, optional 2-entry skid buffer.
// Define PIPE_STAGE_PERF_EN to add saturating stall_cnt/bubble_cnt outputs.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 24,
    parameter int unsigned SKID   = 1
) (
    input  logic                    clk,
    input  logic                    Reset,
    pipe_stage_reg_if.slave         in_if,
    pipe_stage_reg_if.master        out_if,
    input  logic                    flush,
    output logic [OCC_W-1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [PERF_W-1:0]       stall_cnt,
    output logic [PERF_W-1:0]       bubble_cnt
`endif
);

    pipe_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

    logic out_valid;
    logic in_ready;
    logic push;
    logic pop;

    always_comb begin
        out_valid = (state_q != EMPTY);
        // With the skid buffer, in_ready is registered-state only, breaking the ready path.
        if (SKID != 0) begin
            in_ready = (state_q != TWO) && !Reset;
        end else begin
            in_ready = (!out_valid || out_if.ready) && !Reset;
        end
        push = in_if.valid && in_ready;
        pop  = out_valid && out_if.ready;
    end

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        main_data_d = in_if.data;
                        main_ctrl_d = in_if.ctrl;
                        state_d     = ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_data_d = in_if.data;
                        main_ctrl_d = in_if.ctrl;
                    end else if (push) begin
                        // Only reachable with SKID=1; SKID=0 never pushes into a stalled head.
                        skid_data_d = in_if.data;
                        skid_ctrl_d = in_if.ctrl;
                        state_d     = TWO;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        main_data_d = skid_data_q;
                        main_ctrl_d = skid_ctrl_q;
                        state_d     = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= EMPTY;
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

    assign in_if.ready  = in_ready;
    assign out_if.valid = out_valid;
    assign out_if.data  = main_data_q;
    // Bubbles must never carry live enables downstream.
    assign out_if.ctrl  = out_valid ? main_ctrl_q : '0;
    assign occupancy    = state_q;

`ifdef PIPE_STAGE_PERF_EN
    logic stall_inc;
    logic bubble_inc;

    assign stall_inc  = out_valid && !out_if.ready;
    assign bubble_inc = (!out_valid && !Reset) || flush;

    pipe_sat_counter #(
        .WIDTH (PERF_W)
    ) u_stall_cnt (
        .clk     (clk),
        .Reset   (Reset),
        .inc_i   (stall_inc),
        .count_o (stall_cnt)
    );

    pipe_sat_counter #(
        .WIDTH (PERF_W)
    ) u_bubble_cnt (
        .clk     (clk),
        .Reset   (Reset),
        .inc_i   (bubble_inc),
        .count_o (bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: SKID=1 instance for handshake/flush/reset,
// SKID=0 instance for combinational ready and (with PIPE_STAGE_PERF_EN) the counters.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    logic clk;
    logic Reset;
    logic flush1, flush0;
    logic [OCC_W-1:0] occ1, occ0;
`ifdef PIPE_STAGE_PERF_EN
    logic [PERF_W-1:0] stall1, bubble1, stall0, bubble0;
`endif

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(24)) in1 ();
    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(24)) out1 ();
    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(24)) in0 ();
    pipe_stage_reg_if #(.DATA_W(32), .CTRL_W(24)) out0 ();

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(24), .SKID(1)) dut1 (
        .clk       (clk),
        .Reset     (Reset),
        .in_if     (in1),
        .out_if    (out1),
        .flush     (flush1),
        .occupancy (occ1)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt  (stall1),
        .bubble_cnt (bubble1)
`endif
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(24), .SKID(0)) dut0 (
        .clk       (clk),
        .Reset     (Reset),
        .in_if     (in0),
        .out_if    (out0),
        .flush     (flush0),
        .occupancy (occ0)
`ifdef PIPE_STAGE_PERF_EN
        ,
        .stall_cnt  (stall0),
        .bubble_cnt (bubble0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive1(input logic v, input logic [31:0] d, input logic [23:0] c);
        in1.valid = v;
        in1.data  = d;
        in1.ctrl  = c;
    endtask

    initial begin
        Reset      = 1'b1;
        flush1     = 1'b0;
        flush0     = 1'b0;
        drive1(1'b0, 32'h0, 24'h0);
        out1.ready = 1'b0;
        in0.valid  = 1'b0;
        in0.data   = 32'h0;
        in0.ctrl   = 24'h0;
        out0.ready = 1'b0;
        cyc();
        cyc();

        // Reset values
        chk("rst_out_valid", 64'(out1.valid), 64'd0);
        chk("rst_out_data", 64'(out1.data), 64'd0);
        chk("rst_out_ctrl", 64'(out1.ctrl), 64'd0);
        chk("rst_occ", 64'(occ1), 64'd0);
        chk("rst_in_ready", 64'(in1.ready), 64'd0);

        // Stall fill: A, B accepted, C blocked, then drained in order
        Reset = 1'b0;
        drive1(1'b1, 32'hA, 24'h1);
        #1;
        chk("fill_in_ready_a", 64'(in1.ready), 64'd1);
        cyc();
        chk("fill_valid_a", 64'(out1.valid), 64'd1);
        chk("fill_data_a", 64'(out1.data), 64'hA);
        chk("fill_occ_1", 64'(occ1), 64'd1);
        drive1(1'b1, 32'hB, 24'h2);
        #1;
        chk("fill_in_ready_b", 64'(in1.ready), 64'd1);
        cyc();
        chk("fill_occ_2", 64'(occ1), 64'd2);
        chk("fill_hold_a", 64'(out1.data), 64'hA);
        drive1(1'b1, 32'hC, 24'h3);
        #1;
        chk("fill_in_ready_c", 64'(in1.ready), 64'd0);
        cyc();
        chk("stall_occ_2", 64'(occ1), 64'd2);
        chk("stall_data_a", 64'(out1.data), 64'hA);
        chk("stall_ctrl_a", 64'(out1.ctrl), 64'h1);
        out1.ready = 1'b1;
        cyc();
        chk("drain_data_b", 64'(out1.data), 64'hB);
        chk("drain_occ_1", 64'(occ1), 64'd1);
        cyc();
        chk("drain_data_c", 64'(out1.data), 64'hC);
        chk("drain_ctrl_c", 64'(out1.ctrl), 64'h3);
        drive1(1'b0, 32'h0, 24'h0);
        cyc();
        chk("drain_empty", 64'(out1.valid), 64'd0);
        chk("drain_bubble_ctrl", 64'(out1.ctrl), 64'd0);
        chk("drain_data_held", 64'(out1.data), 64'hC);

        // Back-to-back throughput 1..8
        for (int i = 1; i <= 8; i++) begin
            drive1(1'b1, 32'(i), 24'(i));
            #1;
            chk("b2b_in_ready", 64'(in1.ready), 64'd1);
            cyc();
            chk("b2b_valid", 64'(out1.valid), 64'd1);
            chk("b2b_data", 64'(out1.data), 64'(i));
        end
        drive1(1'b0, 32'h0, 24'h0);
        cyc();
        chk("b2b_done", 64'(out1.valid), 64'd0);

        // Single-beat control: only visible while valid
        drive1(1'b1, 32'h55, 24'hFFFFFF);
        #1;
        chk("bub_ctrl_before", 64'(out1.ctrl), 64'd0);
        cyc();
        chk("bub_ctrl_valid", 64'(out1.ctrl), 64'hFFFFFF);
        drive1(1'b0, 32'h0, 24'h0);
        cyc();
        chk("bub_ctrl_after", 64'(out1.ctrl), 64'd0);
        cyc();
        chk("bub_ctrl_after2", 64'(out1.ctrl), 64'd0);

        // Flush at occupancy 2 with a simultaneous push of D
        out1.ready = 1'b0;
        drive1(1'b1, 32'h11, 24'h7);
        cyc();
        drive1(1'b1, 32'h22, 24'h8);
        cyc();
        chk("flush_pre_occ", 64'(occ1), 64'd2);
        drive1(1'b1, 32'hD, 24'h9);
        flush1 = 1'b1;
        cyc();
        flush1 = 1'b0;
        drive1(1'b0, 32'h0, 24'h0);
        #1;
        chk("flush_valid", 64'(out1.valid), 64'd0);
        chk("flush_ctrl", 64'(out1.ctrl), 64'd0);
        chk("flush_occ", 64'(occ1), 64'd0);
        chk("flush_data_held", 64'(out1.data), 64'h11);
        chk("flush_in_ready", 64'(in1.ready), 64'd1);
        out1.ready = 1'b1;
        cyc();
        chk("flush_no_d", 64'(out1.valid), 64'd0);

        // Asynchronous reset while full, then a NOP beat
        out1.ready = 1'b0;
        drive1(1'b1, 32'h31, 24'h1);
        cyc();
        drive1(1'b1, 32'h32, 24'h2);
        cyc();
        chk("mrst_pre_occ", 64'(occ1), 64'd2);
        drive1(1'b0, 32'h0, 24'h0);
        Reset = 1'b1;
        #1;
        chk("mrst_valid", 64'(out1.valid), 64'd0);
        chk("mrst_ctrl", 64'(out1.ctrl), 64'd0);
        chk("mrst_occ", 64'(occ1), 64'd0);
        chk("mrst_in_ready", 64'(in1.ready), 64'd0);
        cyc();
        Reset = 1'b0;
        out1.ready = 1'b1;
        drive1(1'b1, 32'h0000_0013, 24'h5);
        cyc();
        chk("nop_valid", 64'(out1.valid), 64'd1);
        chk("nop_data", 64'(out1.data), 64'h13);
        drive1(1'b0, 32'h0, 24'h0);

        // SKID=0: fresh reset so the counters start from a known cycle
        Reset = 1'b1;
        cyc();
        in0.valid  = 1'b1;
        in0.data   = 32'h77;
        in0.ctrl   = 24'h9;
        out0.ready = 1'b0;
        Reset      = 1'b0;
        #1;
        chk("s0_in_ready_empty", 64'(in0.ready), 64'd1);
        cyc();
        in0.valid = 1'b0;
        chk("s0_valid", 64'(out0.valid), 64'd1);
        chk("s0_data", 64'(out0.data), 64'h77);
        #1;
        chk("s0_in_ready_stall", 64'(in0.ready), 64'd0);
        for (int i = 0; i < 5; i++) cyc();
        chk("s0_hold_data", 64'(out0.data), 64'h77);
`ifdef PIPE_STAGE_PERF_EN
        chk("s0_stall_cnt", 64'(stall0), 64'd5);
`endif
        out0.ready = 1'b1;
        #1;
        chk("s0_in_ready_comb", 64'(in0.ready), 64'd1);
        cyc();
        chk("s0_popped", 64'(out0.valid), 64'd0);
        for (int i = 0; i < 3; i++) cyc();
`ifdef PIPE_STAGE_PERF_EN
        // One bubble on the first post-reset edge plus three idle cycles
        chk("s0_bubble_cnt", 64'(bubble0), 64'd4);
        chk("s0_stall_final", 64'(stall0), 64'd5);
`endif

        // SKID=0 push and pop in the same cycle replaces the head
        in0.valid = 1'b1;
        in0.data  = 32'h81;
        in0.ctrl  = 24'h1;
        cyc();
        in0.data  = 32'h82;
        in0.ctrl  = 24'h2;
        cyc();
        chk("s0_replace_data", 64'(out0.data), 64'h82);
        chk("s0_replace_occ", 64'(occ0), 64'd1);
        in0.valid = 1'b0;
        cyc();
        chk("s0_final_empty", 64'(out0.valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
